// File: rtl/branch_predict_tournament.sv
// -----------------------------------------------------------------------------
// branch_predict_tournament
//
// Tournament branch direction predictor. It has three parts:
//   - a gshare global component: GPHT indexed by pc ^ speculative global history
//   - a local component: per-PC history (BHT) indexing the local PHT
//   - a choice table (CPHT) indexed by pc that picks between the two in MODE 2
//
// The prediction is formed in F and registered into D. The F-stage side
// information travels down the D->E->M pipeline registers. The branch
// resolves in M, and the tables train at the end of that M cycle. The
// speculative global history is repaired from the retired history whenever
// M detects a mispredict.
//
// Parameters
//   PHT_DEPTH  log2 entries of GPHT/LPHT/CPHT; also the GHR and LHR width (>=2)
//   BHT_DEPTH  log2 entries of the local history table
//   MODE       0 = global only, 1 = local only, 2 = tournament
//   CNT_W      width of the saturating performance counters
//
// Ports
//   clk            clock; all state changes on posedge
//   rst            asynchronous active-low reset
//   stallF         freezes the speculative GHR shift for the branch in F
//   stallD         holds the F->D register
//   flushD/E/M     clear the corresponding pipeline register
//   pcF, pcM       fetch PC and resolving-branch PC
//   branchF        a branch is present in F
//   branchM        a branch is resolving in M
//   actual_takeM   resolved direction of the branch in M
//   pred_takeD     registered prediction for the branch in D
//   mispredictM    combinational mispredict flag for the branch in M
//   branch_cnt     resolved-branch count, saturating
//   mispred_cnt    mispredict count, saturating
// -----------------------------------------------------------------------------
module branch_predict_tournament #(
  parameter int PHT_DEPTH = 6,
  parameter int BHT_DEPTH = 6,
  parameter int MODE      = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             flushE,
  input  logic             flushM,
  input  logic [31:0]      pcF,
  input  logic [31:0]      pcM,
  input  logic             branchF,
  input  logic             branchM,
  input  logic             actual_takeM,
  output logic             pred_takeD,
  output logic             mispredictM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PHT_N = 1 << PHT_DEPTH;
  localparam int BHT_N = 1 << BHT_DEPTH;
  localparam int PC_HI = ((PHT_DEPTH > BHT_DEPTH) ? PHT_DEPTH : BHT_DEPTH) + 1;

  typedef logic [PHT_DEPTH-1:0] hist_t;

  // Everything M needs in order to train, captured in F.
  typedef struct packed {
    logic  pred;
    logic  gp;
    logic  lp;
    hist_t g_idx;
    hist_t l_idx;
  } stage_t;

  // 2-bit saturating step: up = increment, otherwise decrement.
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && (c != 2'b11)) begin
      r = c + 2'b01;
    end else if (!up && (c != 2'b00)) begin
      r = c - 2'b01;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] gpht_q [PHT_N];
  logic [1:0] lpht_q [PHT_N];
  logic [1:0] cpht_q [PHT_N];
  hist_t      bht_q  [BHT_N];

  hist_t  ghr_spec_q, ghr_spec_d;
  hist_t  ghr_ret_q,  ghr_ret_d;
  stage_t f_s;
  stage_t d_q, d_d;
  stage_t e_q, e_d;
  stage_t m_q, m_d;

  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------------------------------------------------------------------
  // F: lookup and selection
  // ---------------------------------------------------------------------------
  hist_t                c_idx_f, g_idx_f, l_idx_f;
  logic [BHT_DEPTH-1:0] b_idx_f;
  logic                 gp_f, lp_f, sel_f, pred_f;

  assign c_idx_f = pcF[PHT_DEPTH+1:2];
  assign b_idx_f = pcF[BHT_DEPTH+1:2];
  assign g_idx_f = c_idx_f ^ ghr_spec_q;
  assign l_idx_f = bht_q[b_idx_f];
  assign gp_f    = gpht_q[g_idx_f][1];
  assign lp_f    = lpht_q[l_idx_f][1];

  // The CPHT MSB set means "trust global".
  always_comb begin
    sel_f = gp_f;
    if (MODE == 1) begin
      sel_f = lp_f;
    end else if (MODE == 2) begin
      sel_f = cpht_q[c_idx_f][1] ? gp_f : lp_f;
    end
  end

  assign pred_f = branchF & sel_f;

  always_comb begin
    f_s       = '0;
    f_s.pred  = pred_f;
    f_s.gp    = gp_f;
    f_s.lp    = lp_f;
    f_s.g_idx = g_idx_f;
    f_s.l_idx = l_idx_f;
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. flushD takes priority over stallD.
  // ---------------------------------------------------------------------------
  always_comb begin
    d_d = d_q;
    if (flushD) begin
      d_d = '0;
    end else if (!stallD) begin
      d_d = f_s;
    end
    e_d = flushE ? '0 : d_q;
    m_d = flushM ? '0 : e_q;
  end

  // ---------------------------------------------------------------------------
  // M: resolve and compute training data
  // ---------------------------------------------------------------------------
  hist_t                c_idx_m;
  logic [BHT_DEPTH-1:0] b_idx_m;
  logic [1:0]           gpht_wr_d, lpht_wr_d, cpht_wr_d;
  logic                 cpht_we_d;
  hist_t                bht_wr_d;

  assign c_idx_m = pcM[PHT_DEPTH+1:2];
  assign b_idx_m = pcM[BHT_DEPTH+1:2];

  // Gated by rst so that every output reads 0 while reset is asserted,
  // even if branchM/actual_takeM are being driven.
  assign mispredictM = rst & branchM & (actual_takeM ^ m_q.pred);

  always_comb begin
    gpht_wr_d = sat2(gpht_q[m_q.g_idx], actual_takeM);
    lpht_wr_d = sat2(lpht_q[m_q.l_idx], actual_takeM);
    bht_wr_d  = {bht_q[b_idx_m][PHT_DEPTH-2:0], actual_takeM};
    // The chooser only learns when the two components disagreed; it moves
    // toward whichever one was right.
    cpht_we_d = (MODE == 2) && branchM && (m_q.gp != m_q.lp);
    cpht_wr_d = sat2(cpht_q[c_idx_m], m_q.gp == actual_takeM);
  end

  // ---------------------------------------------------------------------------
  // Global history. A mispredict repair overrides a concurrent F shift,
  // because the branch in F lies on the wrong path.
  // ---------------------------------------------------------------------------
  always_comb begin
    ghr_spec_d = ghr_spec_q;
    if (mispredictM) begin
      ghr_spec_d = {ghr_ret_q[PHT_DEPTH-2:0], actual_takeM};
    end else if (branchF && !stallF) begin
      ghr_spec_d = {ghr_spec_q[PHT_DEPTH-2:0], pred_f};
    end
    ghr_ret_d = ghr_ret_q;
    if (branchM) begin
      ghr_ret_d = {ghr_ret_q[PHT_DEPTH-2:0], actual_takeM};
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (branchM && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredictM && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_spec_q    <= '0;
      ghr_ret_q     <= '0;
      d_q           <= '0;
      e_q           <= '0;
      m_q           <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_spec_q    <= ghr_spec_d;
      ghr_ret_q     <= ghr_ret_d;
      d_q           <= d_d;
      e_q           <= e_d;
      m_q           <= m_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Table writes land at the end of the M cycle. There is no bypass: an F
  // read in that same cycle still sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_N; i++) begin
        gpht_q[i] <= 2'b10;
        lpht_q[i] <= 2'b10;
        cpht_q[i] <= 2'b10;
      end
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= '0;
      end
    end else begin
      if (branchM) begin
        gpht_q[m_q.g_idx] <= gpht_wr_d;
        lpht_q[m_q.l_idx] <= lpht_wr_d;
        bht_q[b_idx_m]    <= bht_wr_d;
      end
      if (cpht_we_d) begin
        cpht_q[c_idx_m] <= cpht_wr_d;
      end
    end
  end

  assign pred_takeD  = d_q.pred;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // PC bits outside the index fields, and the retired-history bit that is
  // always shifted out, are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{pcF[31:PC_HI+1], pcF[1:0], pcM[31:PC_HI+1], pcM[1:0],
                         ghr_ret_q[PHT_DEPTH-1]};

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Bench for branch_predict_tournament. Three instances (MODE 0/1/2) share
// one stimulus stream. A table-level reference model predicts, for every
// cycle, pred_takeD, mispredictM and both counters of each instance.
module tb_branch_predict_tournament;

  localparam int PD    = 6;
  localparam int BD    = 6;
  localparam int CW    = 4;
  localparam int NENT  = 1 << PD;
  localparam int HMASK = NENT - 1;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int EW    = 2 + 2 * CW;
  localparam int QW    = 3 * EW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic stallF, stallD, flushD, flushE, flushM;
  logic [31:0] pcF, pcM;
  logic branchF, branchM, actual_takeM;
  logic [2:0] dut_pred, dut_mis;
  logic [2:0][CW-1:0] dut_bc, dut_mc;

  always #5 clk = ~clk;

  branch_predict_tournament #(.PHT_DEPTH(PD), .BHT_DEPTH(BD), .MODE(0), .CNT_W(CW)) u_glob (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM), .branchF(branchF),
    .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeD(dut_pred[0]),
    .mispredictM(dut_mis[0]), .branch_cnt(dut_bc[0]), .mispred_cnt(dut_mc[0]));

  branch_predict_tournament #(.PHT_DEPTH(PD), .BHT_DEPTH(BD), .MODE(1), .CNT_W(CW)) u_loc (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM), .branchF(branchF),
    .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeD(dut_pred[1]),
    .mispredictM(dut_mis[1]), .branch_cnt(dut_bc[1]), .mispred_cnt(dut_mc[1]));

  branch_predict_tournament #(.PHT_DEPTH(PD), .BHT_DEPTH(BD), .MODE(2), .CNT_W(CW)) u_tour (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .pcF(pcF), .pcM(pcM), .branchF(branchF),
    .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeD(dut_pred[2]),
    .mispredictM(dut_mis[2]), .branch_cnt(dut_bc[2]), .mispred_cnt(dut_mc[2]));

  // ---------------- reference model ----------------
  // One record per fetched instruction, holding what each mode predicted.
  typedef struct packed {
    logic              br;
    logic [31:0]       pc;
    logic              act;
    logic [2:0]        pred;
    logic [2:0]        gp;
    logic [2:0]        lp;
    logic [2:0][PD-1:0] gi;
    logic [2:0][PD-1:0] li;
  } rec_t;

  int   gpht [3][NENT];
  int   lpht [3][NENT];
  int   cpht [3][NENT];
  int   bht  [3][NENT];
  int   ghr_s [3];
  int   ghr_r [3];
  int   bcnt  [3];
  int   mcnt  [3];
  rec_t slot_d, slot_e, slot_m;

  logic [QW-1:0] exp_q [$];
  logic [QW-1:0] mon_e;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;
  bit  loop_watch = 0;
  int  loop_mis = 0;

  function automatic int sat_step(input int c, input logic up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < NENT; i++) begin
        gpht[m][i] = 2; lpht[m][i] = 2; cpht[m][i] = 2; bht[m][i] = 0;
      end
      ghr_s[m] = 0; ghr_r[m] = 0; bcnt[m] = 0; mcnt[m] = 0;
    end
    slot_d = '0; slot_e = '0; slot_m = '0;
  endtask

  task automatic chk(input string name, input int m, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s mode%0d: got %0d expected %0d (t=%0t)", name, m, got, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1. Drives F from the arguments and M from the record
  // the model holds in M, pushes the expectation for this cycle, advances
  // the model to the next edge, and returns at the next posedge+1.
  task automatic cycle(input logic bf, input logic [31:0] pc, input logic act,
                       input logic sf, input logic sd, input logic fd,
                       input logic fe, input logic fm);
    rec_t          nr;
    logic [QW-1:0] ent;
    branchF = bf; pcF = pc; stallF = sf; stallD = sd;
    flushD = fd; flushE = fe; flushM = fm;
    branchM = slot_m.br; pcM = slot_m.pc; actual_takeM = slot_m.act;
    nr = '0; nr.br = bf; nr.pc = pc; nr.act = act;
    ent = '0;
    for (int m = 0; m < 3; m++) begin
      int   pi, gi, li, mi;
      logic gp, lp, sel, pf, mis, tk;
      pi  = int'((pc >> 2) & HMASK);
      gi  = pi ^ ghr_s[m];
      li  = bht[m][pi];
      gp  = (gpht[m][gi] >= 2);
      lp  = (lpht[m][li] >= 2);
      if (m == 0) sel = gp;
      else if (m == 1) sel = lp;
      else sel = (cpht[m][pi] >= 2) ? gp : lp;
      pf  = bf & sel;
      nr.pred[m] = pf; nr.gp[m] = gp; nr.lp[m] = lp;
      nr.gi[m] = PD'(gi); nr.li[m] = PD'(li);
      tk  = slot_m.act;
      mis = slot_m.br & (tk != slot_m.pred[m]);
      ent[m*EW +: EW] = {slot_d.pred[m], mis, CW'(bcnt[m]), CW'(mcnt[m])};
      // effects of the coming edge
      if (slot_m.br) begin
        mi = int'((slot_m.pc >> 2) & HMASK);
        gpht[m][slot_m.gi[m]] = sat_step(gpht[m][slot_m.gi[m]], tk);
        lpht[m][slot_m.li[m]] = sat_step(lpht[m][slot_m.li[m]], tk);
        if (m == 2 && slot_m.gp[m] != slot_m.lp[m])
          cpht[m][mi] = sat_step(cpht[m][mi], slot_m.gp[m] == tk);
        bht[m][mi] = ((bht[m][mi] << 1) | int'(tk)) & HMASK;
      end
      if (mis) ghr_s[m] = ((ghr_r[m] << 1) | int'(tk)) & HMASK;
      else if (bf && !sf) ghr_s[m] = ((ghr_s[m] << 1) | int'(pf)) & HMASK;
      if (slot_m.br) begin
        ghr_r[m] = ((ghr_r[m] << 1) | int'(tk)) & HMASK;
        if (bcnt[m] < MAXC) bcnt[m]++;
      end
      if (mis && mcnt[m] < MAXC) mcnt[m]++;
    end
    exp_q.push_back(ent);
    slot_m = fm ? '0 : slot_e;
    slot_e = fe ? '0 : slot_d;
    if (fd) slot_d = '0;
    else if (!sd) slot_d = nr;
    @(posedge clk); #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_inputs();
    branchF = 0; pcF = '0; stallF = 0; stallD = 0; flushD = 0; flushE = 0; flushM = 0;
    branchM = 0; pcM = '0; actual_takeM = 0;
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk({tag, "_pred_takeD"}, m, int'(dut_pred[m]), 0);
      chk({tag, "_mispredictM"}, m, int'(dut_mis[m]), 0);
      chk({tag, "_branch_cnt"}, m, int'(dut_bc[m]), 0);
      chk({tag, "_mispred_cnt"}, m, int'(dut_mc[m]), 0);
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    mon_en = 0;
    idle_inputs();
    branchM = 1; actual_takeM = 1;
    #2 rst = 0;
    #1 check_zero("midrst");
    exp_q.delete();
    model_reset();
    idle_inputs();
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        for (int m = 0; m < 3; m++) begin
          chk("pred_takeD", m, int'(dut_pred[m]), int'(mon_e[m*EW + EW - 1]));
          chk("mispredictM", m, int'(dut_mis[m]), int'(mon_e[m*EW + EW - 2]));
          chk("branch_cnt", m, int'(dut_bc[m]), int'(mon_e[m*EW + CW +: CW]));
          chk("mispred_cnt", m, int'(dut_mc[m]), int'(mon_e[m*EW +: CW]));
        end
        if (loop_watch && dut_mis[1]) loop_mis++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 0;
    branchF = 1; pcF = 32'h100; branchM = 1; actual_takeM = 1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    idle_inputs();
    #2 rst = 1;
    @(posedge clk); #1;
    model_reset();
    mon_en = 1;

    // same branch taken three times, each resolved before the next fetch
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bubbles(3);
    end

    // mispredict in M while another branch is in F
    cycle(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bubbles(2);
    cycle(1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h184, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bubbles(4);

    // loop pattern T,T,T,N x20 at one PC
    for (int it = 0; it < 20; it++) begin
      if (it == 12) loop_watch = 1;
      for (int k = 0; k < 4; k++) begin
        cycle(1'b1, 32'h200, (k != 3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bubbles(3);
      end
    end
    loop_watch = 0;
    chk("loop_last8_mispredicts", 1, loop_mis, 0);

    // stall D and F with a branch in F, then flush D during the stall
    cycle(1'b1, 32'h240, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h244, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h244, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bubbles(4);

    // randomized traffic with occasional stalls and flushes
    for (int i = 0; i < 600; i++) begin
      logic sd;
      sd = ($urandom_range(0, 9) == 0);
      cycle(1'($urandom_range(0, 9) < 6), 32'h1000 + 32'($urandom_range(0, 7)) * 4,
            1'($urandom_range(0, 1)), sd | ($urandom_range(0, 15) == 0), sd,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0));
    end
    bubbles(4);

    // back-to-back branches on two PCs: frequent same-cycle read/write hits
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 32'h100 + 32'($urandom_range(0, 1)) * 4, 1'($urandom_range(0, 3) == 0),
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bubbles(4);

    mid_reset();

    // first post-reset fetches, then more random traffic
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 3)) * 4,
            1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bubbles(4);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
